// File: rtl/mem_reader.sv
// mem_reader: steps through a MEM16x8 one byte per button press.
// A start request latches the byte count, then each byte is fetched from the
// synchronous memory, presented on value/index, and held until btn_next is
// pressed again. A one-cycle done pulse marks the end of the readback.
// Optional feature: define MEM_READER_AUTO_EN to also advance automatically
// after DWELL_CYCLES clk cycles in the SHOW state.
module mem_reader #(
    parameter int unsigned DWELL_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] count,
    input  logic       btn_next,
    output logic [3:0] mem_addr,
    output logic       mem_wr,
    input  logic [7:0] mem_data_in,
    output logic [7:0] value,
    output logic [3:0] index,
    output logic       value_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_SHOW,
        S_FINISH
    } state_t;

    state_t     state;
    logic [3:0] idx;       // address of the byte being fetched/shown
    logic [4:0] len;       // number of bytes in this readback, 1..16
    logic       btn_prev;  // btn_next level seen on the previous cycle
    logic       btn_rise;
    logic       last_byte;
    logic       advance;

    // A zero-length dwell would advance forever; refuse to elaborate it.
    if (DWELL_CYCLES == 0) begin : g_dwell_check
        $error("mem_reader: DWELL_CYCLES must be at least 1");
    end

    // NOTE: continuous assigns, not 'logic x = expr;' -- a declaration
    // initialiser is evaluated once and would never track its inputs.
    assign btn_rise  = btn_next & ~btn_prev;
    assign last_byte = ({1'b0, idx} + 5'd1) == len;

    // The address follows idx directly, so it only moves when idx moves.
    assign mem_addr = idx;
    assign mem_wr   = 1'b0;

    // Track the previous btn_next level so only a 0->1 transition counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev <= 1'b0;
        end else begin
            btn_prev <= btn_next;
        end
    end

`ifdef MEM_READER_AUTO_EN
    localparam int unsigned DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    logic [DWELL_W-1:0] dwell_cnt;
    logic               dwell_hit;

    assign dwell_hit = dwell_cnt == DWELL_W'(DWELL_CYCLES - 1);
    // Either source alone is enough; both together still give one advance.
    assign advance   = btn_rise | dwell_hit;

    // Dwell counter runs only while showing a byte; it is zero on SHOW entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
        end else if (state == S_SHOW && !advance) begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
        end else begin
            dwell_cnt <= '0;
        end
    end
`else
    assign advance = btn_rise;
`endif

    // Readback sequencer: all outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= 4'd0;
            len         <= 5'd0;
            value       <= 8'd0;
            index       <= 4'd0;
            value_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch reads the state
            // as it was before this edge regardless of statement order.
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len         <= (count == 5'd0 || count > 5'd16) ? 5'd16 : count;
                        idx         <= 4'd0;
                        value_valid <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_FETCH;
                    end
                end
                // Address is on mem_addr this cycle; data returns next cycle.
                S_FETCH: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    value       <= mem_data_in;
                    index       <= idx;
                    value_valid <= 1'b1;
                    state       <= S_SHOW;
                end
                // Edges arriving in FETCH/CAPTURE were already absorbed by
                // btn_prev, so a held button cannot re-trigger here.
                S_SHOW: begin
                    if (advance) begin
                        if (last_byte) begin
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= S_FETCH;
                        end
                    end
                end
                // start is not sampled here, so a request this cycle is lost.
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_reader.sv
// Testbench for mem_reader: randomized readbacks against a queue-based
// reference of the bytes each readback must present, plus directed cases for
// clamping, held buttons, ignored starts, and asynchronous reset.
module tb_mem_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] count;
    logic       btn_next;
    logic [3:0] mem_addr;
    logic       mem_wr;
    logic [7:0] mem_data_in;
    logic [7:0] value;
    logic [3:0] index;
    logic       value_valid;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] v;
        logic [3:0] i;
    } exp_item_t;

    exp_item_t  exp_q[$];
    int         exp_done = 0;
    logic [7:0] mem [16];

    mem_reader #(.DWELL_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .count       (count),
        .btn_next    (btn_next),
        .mem_addr    (mem_addr),
        .mem_wr      (mem_wr),
        .mem_data_in (mem_data_in),
        .value       (value),
        .index       (index),
        .value_valid (value_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // MEM16x8 model: data for an address appears one cycle later.
    always @(posedge clk) mem_data_in <= mem[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: each newly presented byte and each done pulse is matched
    // against what the stimulus said should happen.
    logic       prev_vv  = 1'b0;
    logic [3:0] prev_idx = 4'd0;
    exp_item_t  mon_item;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vv  = 1'b0;
            prev_idx = 4'd0;
        end else begin
            if (value_valid && (!prev_vv || index != prev_idx)) begin
                check("value_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_item = exp_q.pop_front();
                    check("value", value, mon_item.v);
                    check("index", index, mon_item.i);
                    check("mem_wr", mem_wr, 0);
                end
            end
            if (done) begin
                check("done_pending", exp_done > 0, 1);
                if (exp_done > 0) begin
                    exp_done--;
                    check("done_busy", busy, 1);
                end
            end
            prev_vv  = value_valid;
            prev_idx = index;
        end
    end

    // Reference: a readback of c bytes presents mem[0..L-1] then one done.
    task automatic start_readback(input int c, input bit press_early);
        int l;
        l = (c == 0 || c > 16) ? 16 : c;
        for (int i = 0; i < l; i++) exp_q.push_back('{v: mem[i], i: 4'(i)});
        exp_done++;
        @(negedge clk);
        start = 1'b1;
        count = 5'(c);
        @(negedge clk);
        start = 1'b0;
        if (press_early) btn_next = 1'b1;
        @(negedge clk);
        check("latency_vv_low", value_valid, 0);
        @(negedge clk);
        check("latency_vv_high", value_valid, 1);
        check("latency_busy", busy, 1);
    endtask

    // One press held for 'hold' cycles, then enough idle to be back in SHOW.
    task automatic press(input int hold);
        @(negedge clk);
        btn_next = 1'b1;
        repeat (hold) @(negedge clk);
        btn_next = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_drained(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_done_seen"}, exp_done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int c;
        int l;
        rst_n    = 1'b0;
        start    = 1'b0;
        count    = 5'd0;
        btn_next = 1'b0;
        randomize_mem();
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_vv", value_valid, 0);
        check("reset_mem_wr", mem_wr, 0);
        check("reset_addr", mem_addr, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef MEM_READER_AUTO_EN
        // Dwell of 4 with no presses: byte 1 after 4 SHOW cycles, then done.
        start_readback(2, 1'b0);
        repeat (5) @(negedge clk);
        check("auto_before_dwell", index, 0);
        @(negedge clk);
        check("auto_advanced", index, 1);
        repeat (4) @(negedge clk);
        check("auto_done", done, 1);
        check_drained("auto");
`else
        // Three presses over 11/22/33.
        start_readback(3, 1'b0);
        for (int i = 0; i < 3; i++) press(1);
        check_drained("basic");

        // count=0 clamps to 16; last byte at address 15, no wrap.
        randomize_mem();
        mem[15] = 8'hA5;
        start_readback(0, 1'b0);
        for (int i = 0; i < 15; i++) press(1 + (i % 3));
        check("full_last_value", value, 8'hA5);
        check("full_last_index", index, 15);
        press(1);
        check("full_no_wrap_addr", mem_addr, 15);
        check("full_hold_index", index, 15);
        check("full_hold_vv", value_valid, 1);
        check_drained("full");

        // Press during FETCH is discarded; held press gives one advance;
        // start mid-readback and start during FINISH are ignored.
        randomize_mem();
        start_readback(3, 1'b1);
        repeat (3) @(negedge clk);
        btn_next = 1'b0;
        repeat (3) @(negedge clk);
        check("fetch_press_ignored", index, 0);
        press(20);
        check("held_single_advance", index, 1);
        @(negedge clk);
        start = 1'b1;
        count = 5'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_start_busy", busy, 1);
        check("mid_start_index", index, 1);
        press(1);
        check("orig_len_continues", index, 2);
        @(negedge clk);
        btn_next = 1'b1;
        @(negedge clk);
        btn_next = 1'b0;
        start    = 1'b1;
        count    = 5'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("finish_start_ignored", busy, 0);
        check("finish_hold_vv", value_valid, 1);
        check_drained("ignore");

        // Asynchronous reset while showing index 4.
        randomize_mem();
        start_readback(8, 1'b0);
        for (int i = 0; i < 4; i++) press(1);
        check("pre_reset_index", index, 4);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        exp_done = 0;
        #1;
        check("async_value", value, 0);
        check("async_index", index, 0);
        check("async_vv", value_valid, 0);
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_addr", mem_addr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle", busy, 0);
        start_readback(2, 1'b0);
        for (int i = 0; i < 2; i++) press(1);
        check_drained("post_reset");

        // Randomized readbacks, counts across the whole 5-bit range.
        for (int r = 0; r < 6; r++) begin
            randomize_mem();
            c = int'($urandom_range(0, 31));
            l = (c == 0 || c > 16) ? 16 : c;
            start_readback(c, 1'b0);
            for (int i = 0; i < l; i++) begin
                press(int'($urandom_range(1, 5)));
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            check_drained("random");
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_reader.md
MEM_READER -- requirements
Module: mem_reader

Interface
REQ-001 The block SHALL have parameter DWELL_CYCLES, default 50000000, giving the auto-advance dwell in clk cycles; it is used only when MEM_READER_AUTO_EN is defined.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, a single-cycle request to begin readback.
REQ-005 The block SHALL have port count, input, 5, the number of bytes to read, sampled when start is accepted.
REQ-006 The block SHALL have port btn_next, input, 1, active-high debounced level that advances to the next byte.
REQ-007 The block SHALL have port mem_addr, output, 4, the MEM16x8 read address.
REQ-008 The block SHALL have port mem_wr, output, 1, tied to 0.
REQ-009 The block SHALL have port mem_data_in, input, 8, MEM16x8 DATA_OUT, valid exactly one cycle after mem_addr is driven.
REQ-010 The block SHALL have port value, output, 8, the byte currently presented.
REQ-011 The block SHALL have port index, output, 4, the address of the byte in value.
REQ-012 The block SHALL have port value_valid, output, 1, high while value holds a fetched byte.
REQ-013 The block SHALL have port busy, output, 1, high in every state other than IDLE.
REQ-014 The block SHALL have port done, output, 1, a one-cycle pulse when readback completes.

Function
REQ-015 The FSM SHALL have the states IDLE, FETCH, CAPTURE, SHOW and FINISH.
REQ-016 In IDLE, start=1 SHALL latch len = count, with 0 or any value above 16 clamped to 16, set idx=0, clear value_valid, and move to FETCH.
REQ-017 In FETCH, the block SHALL drive mem_addr=idx for one cycle, then move to CAPTURE.
REQ-018 In CAPTURE, the block SHALL register value<=mem_data_in, index<=idx and value_valid<=1, then move to SHOW; start-to-first-value_valid latency is exactly 3 cycles.
REQ-019 mem_addr SHALL hold idx in every state, so address changes happen only on idx updates.
REQ-020 In SHOW, a rising edge of btn_next (level 1 this cycle, 0 the previous cycle) SHALL advance; if idx+1==len the FSM goes to FINISH, otherwise idx increments and the FSM goes to FETCH.
REQ-021 A btn_next held high SHALL produce exactly one advance; a rising edge occurring in FETCH or CAPTURE SHALL be discarded, and advancing again requires release and re-press in SHOW.
REQ-022 In FINISH, done SHALL be 1 for exactly one cycle, then the FSM returns to IDLE; value, index and value_valid hold their last contents.
REQ-023 start while busy=1 SHALL be ignored; start in the same cycle as FINISH SHALL also be ignored.
REQ-024 idx SHALL never exceed 15 and SHALL never wrap within a readback; len=16 ends after address 15.
REQ-025 mem_wr SHALL be 0 in every state, including during reset.

Reset
REQ-026 rst_n=0 SHALL immediately, without a clock, force: state=IDLE, idx=0, len=0, mem_addr=0, value=0, index=0, value_valid=0, busy=0, done=0, btn_next edge register=0, dwell counter=0.
REQ-027 Reset asserted mid-readback SHALL abort with no done pulse; after release, the block waits in IDLE for a new start.

Configuration
REQ-028 With MEM_READER_AUTO_EN defined, SHOW SHALL also advance when a dwell counter, cleared on entry to SHOW, reaches DWELL_CYCLES-1; btn_next still advances immediately, and either source produces a single advance.
REQ-029 Without MEM_READER_AUTO_EN, no dwell counter SHALL exist, and SHOW advances only on a btn_next rising edge.

Verification
REQ-030 Preload mem[0..2]=8'h11,8'h22,8'h33; start with count=3; three btn_next pulses -> value 11/22/33 with index 0/1/2, value_valid 3 cycles after start, done pulse after the third press.
REQ-031 count=0, mem[15]=8'hA5 -> 16 bytes read; after the 15th press value=A5, index=15; the 16th press gives done and no wrap to address 0.
REQ-032 btn_next held high for 20 cycles in SHOW -> exactly one advance; a press issued during FETCH is ignored.
REQ-033 start pulsed again mid-readback with count=2 -> no effect, and the original len completes.
REQ-034 rst_n low during SHOW at idx=4 -> all outputs 0 asynchronously, no done; the next start reads from address 0.
REQ-035 MEM_READER_AUTO_EN with DWELL_CYCLES=4, count=2, no presses -> value advances 4 cycles after entering SHOW; done follows the second dwell.
